// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: replays a loadable (register, value) table to an I2C device with retry, timeout and gap control
module i2c_config_sequencer #(
  parameter int DEPTH = 32,
  parameter logic [6:0] DEV_ADDR = 7'h72,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TIMEOUT = 1023,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_reg,
  input  logic [7:0]       tbl_val,
  input  logic [IDX_W:0]   count,
  input  logic             start,
  input  logic             i2c_busy,
  input  logic             i2c_nack,
  output logic [6:0]       address,
  output logic [7:0]       data_0,
  output logic [7:0]       data_1,
  output logic             i2c_start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] fail_idx
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = BUSY_TIMEOUT > 0 ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [IDX_W:0] DEPTH_N = (IDX_W + 1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, GAP, DONE, ERROR} state_t;
  state_t state, state_next, after_write;
  logic [IDX_W:0] idx, n, n_in;
  logic [RW-1:0] retry;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] mem_reg [DEPTH];
  logic [7:0] mem_val [DEPTH];
  logic ready, go, last, retry_max;
  assign address = DEV_ADDR;
  assign busy = !ready;
  assign done = state == DONE;
  assign error = state == ERROR;
  always_comb begin
    ready = state == IDLE || state == DONE || state == ERROR;
    go = ready && start;
    n_in = count > DEPTH_N ? DEPTH_N : count;
    last = idx + 1'b1 == n;
    retry_max = retry == RW'(MAX_RETRY);
    after_write = GAP_CYCLES == 0 ? LOAD : GAP;
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: state_next = go ? (n_in == '0 ? DONE : LOAD) : state;
      LOAD:    state_next = ISSUE;
      ISSUE:   state_next = i2c_busy ? ISSUE : WAIT_HI;
      WAIT_HI: state_next = i2c_busy ? WAIT_LO : (to_cnt == TW'(BUSY_TIMEOUT) ? ERROR : WAIT_HI);
      WAIT_LO: state_next = i2c_busy ? WAIT_LO : !i2c_nack ? (last ? DONE : after_write) : (retry_max ? ERROR : after_write);
      GAP:     state_next = gap_cnt == GW'(GAP_CYCLES - 1) ? LOAD : GAP;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (tbl_we && ready && {1'b0, tbl_idx} < DEPTH_N) begin
      mem_reg[tbl_idx] <= tbl_reg;
      mem_val[tbl_idx] <= tbl_val;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      n         <= '0;
      retry     <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      data_0    <= '0;
      data_1    <= '0;
      i2c_start <= 1'b0;
      fail_idx  <= '0;
    end else begin
      state     <= state_next;
      i2c_start <= state == ISSUE && !i2c_busy;
      if (go) begin
        n     <= n_in;
        idx   <= '0;
        retry <= '0;
      end
      if (state == LOAD) begin
        data_0 <= mem_reg[idx[IDX_W-1:0]];
        data_1 <= mem_val[idx[IDX_W-1:0]];
      end
      if (state == ISSUE) to_cnt <= '0;
      if (state == WAIT_HI && !i2c_busy) to_cnt <= to_cnt + 1'b1;
      if (state == GAP) gap_cnt <= state_next == GAP ? gap_cnt + 1'b1 : '0;
      if (state == WAIT_LO && !i2c_busy) begin
        idx   <= i2c_nack ? idx : idx + 1'b1;
        retry <= !i2c_nack ? '0 : (retry_max ? retry : retry + 1'b1);
      end
      if (state_next == ERROR && state != ERROR) fail_idx <= idx[IDX_W-1:0];
    end
  end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: directed scenarios against a behavioural byte-pair master model
module tb_i2c_config_sequencer;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int GAP = 16;
  logic clk = 0, rst = 1, tbl_we = 0, start = 0;
  logic [IDX_W-1:0] tbl_idx = '0;
  logic [7:0] tbl_reg = '0, tbl_val = '0;
  logic [IDX_W:0] count = '0;
  logic i2c_busy = 0, i2c_nack = 0;
  logic [6:0] address;
  logic [7:0] data_0, data_1;
  logic i2c_start, busy, done, error;
  logic [IDX_W-1:0] fail_idx;
  int checks = 0, passed = 0;
  int cyc = 0, pulses = 0, m_cnt = 0, nacks = 0, fall_cyc = -1000;
  bit m_en = 1;
  logic [7:0] nack_reg = 8'h00;
  int nack_base = 0, nack_lim = 0;
  logic [7:0] reg_log [256];
  logic [7:0] val_log [256];
  int start_cyc [256];
  int fall_log [256];
  logic st_q;

  i2c_config_sequencer #(.DEPTH(DEPTH), .DEV_ADDR(7'h72), .MAX_RETRY(3), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_reg(tbl_reg), .tbl_val(tbl_val),
    .count(count), .start(start), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack), .address(address),
    .data_0(data_0), .data_1(data_1), .i2c_start(i2c_start), .busy(busy), .done(done), .error(error),
    .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    st_q = i2c_start;
    if (st_q) begin
      if (pulses < 256) begin
        reg_log[pulses] = data_0;
        val_log[pulses] = data_1;
        start_cyc[pulses] = cyc;
        fall_log[pulses] = fall_cyc;
      end
      pulses++;
    end
    #1;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        i2c_busy = 0;
        i2c_nack = (data_0 == nack_reg) && (nacks - nack_base < nack_lim);
        if (i2c_nack) nacks++;
        fall_cyc = cyc;
      end
    end else if (st_q && m_en) begin
      m_cnt = 40;
      i2c_busy = 1;
      i2c_nack = 0;
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic write_entry(input int i, input logic [7:0] r, input logic [7:0] v);
    tbl_we = 1; tbl_idx = IDX_W'(i); tbl_reg = r; tbl_val = v;
    tick();
    tbl_we = 0;
  endtask

  task automatic load_basic();
    write_entry(0, 8'h01, 8'h00);
    write_entry(1, 8'h02, 8'h18);
    write_entry(2, 8'h03, 8'h00);
  endtask

  task automatic pulse_start(input int c);
    count = (IDX_W + 1)'(c); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_end(input int budget, output int t);
    t = 0;
    while (!(done || error) && t < budget) begin
      tick();
      t++;
    end
  endtask

  task automatic wait_master_idle();
    for (int i = 0; i < 100 && m_cnt != 0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(2);
    checks++;
    if ({busy, done, error, i2c_start} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {busy, done, error, i2c_start});
    else passed++;
    checks++;
    if ({data_0, data_1, fail_idx} !== '0) $display("FAIL reset_data: got %h %h %h want 0", data_0, data_1, fail_idx);
    else passed++;
    checks++;
    if (address !== 7'h72) $display("FAIL reset_address: got %h want 72", address);
    else passed++;
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] er [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] ev [3] = '{8'h00, 8'h18, 8'h00};
    int base, t, bad, mg;
    load_basic();
    base = pulses;
    pulse_start(3);
    wait_end(500, t);
    checks++;
    if (t >= 500) $display("FAIL basic_timeout: waited %0d cycles without done", t);
    else passed++;
    checks++;
    if (pulses - base != 3) $display("FAIL basic_pulses: got %0d want 3", pulses - base);
    else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) if (reg_log[base + i] !== er[i] || val_log[base + i] !== ev[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL basic_order: %0d of 3 pairs wrong, first got %h:%h want 01:00", bad, reg_log[base], val_log[base]);
    else passed++;
    mg = 1000;
    for (int i = 1; i < 3; i++) if (start_cyc[base + i] - fall_log[base + i] - 1 < mg) mg = start_cyc[base + i] - fall_log[base + i] - 1;
    checks++;
    if (mg < GAP) $display("FAIL basic_gap: got %0d idle clocks want >= %0d", mg, GAP);
    else passed++;
    checks++;
    if ({done, busy, error} !== 3'b100) $display("FAIL basic_status: got done/busy/error %b want 100", {done, busy, error});
    else passed++;
  endtask

  task automatic test_nack_retry();
    logic [7:0] er [4] = '{8'h01, 8'h02, 8'h02, 8'h03};
    int base, t, bad;
    nack_reg = 8'h02; nack_base = nacks; nack_lim = 1;
    base = pulses;
    pulse_start(3);
    wait_end(800, t);
    nack_lim = 0;
    checks++;
    if (pulses - base != 4) $display("FAIL nack_pulses: got %0d want 4", pulses - base);
    else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (reg_log[base + i] !== er[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL nack_order: %0d of 4 registers wrong, third got %h want 02", bad, reg_log[base + 2]);
    else passed++;
    checks++;
    if ({done, error} !== 2'b10) $display("FAIL nack_status: got done/error %b want 10", {done, error});
    else passed++;
  endtask

  task automatic test_retry_exhaust();
    int base, t, bad;
    nack_reg = 8'h03; nack_base = nacks; nack_lim = 100;
    base = pulses;
    pulse_start(3);
    wait_end(1500, t);
    checks++;
    if ({done, error, busy} !== 3'b010) $display("FAIL exhaust_status: got done/error/busy %b want 010", {done, error, busy});
    else passed++;
    checks++;
    if (fail_idx !== 5'd2) $display("FAIL exhaust_fail_idx: got %0d want 2", fail_idx);
    else passed++;
    bad = 0;
    for (int i = 2; i < 6; i++) if (reg_log[base + i] !== 8'h03) bad++;
    checks++;
    if (pulses - base != 6 || bad != 0) $display("FAIL exhaust_pulses: got %0d pulses (%0d bad) want 6", pulses - base, bad);
    else passed++;
    tick(100);
    checks++;
    if (pulses - base != 6) $display("FAIL exhaust_quiet: got %0d pulses want 6", pulses - base);
    else passed++;
    nack_lim = 0;
  endtask

  task automatic test_count_zero();
    int base;
    base = pulses;
    pulse_start(0);
    tick();
    checks++;
    if ({done, error, busy} !== 3'b100 || pulses != base) $display("FAIL zero_count: got done/error/busy %b pulses %0d want 100 and 0", {done, error, busy}, pulses - base);
    else passed++;
  endtask

  task automatic test_timeout();
    int base, t;
    m_en = 0;
    base = pulses;
    pulse_start(3);
    wait_end(1200, t);
    checks++;
    if ({error, done} !== 2'b10 || fail_idx !== 5'd0) $display("FAIL timeout_status: got error/done %b fail_idx %0d want 10 and 0", {error, done}, fail_idx);
    else passed++;
    checks++;
    if (t < 1023 || t > 1030) $display("FAIL timeout_latency: got %0d cycles want 1023..1030", t);
    else passed++;
    checks++;
    if (pulses - base != 1) $display("FAIL timeout_pulses: got %0d want 1", pulses - base);
    else passed++;
    m_en = 1;
    base = pulses;
    pulse_start(3);
    wait_end(500, t);
    checks++;
    if ({done, error} !== 2'b10 || pulses - base != 3) $display("FAIL timeout_recover: got done/error %b pulses %0d want 10 and 3", {done, error}, pulses - base);
    else passed++;
  endtask

  task automatic test_count_sat();
    int base, t, bad;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 8'(i), 8'(8'hA0 + i));
    base = pulses;
    pulse_start(40);
    wait_end(4000, t);
    checks++;
    if (pulses - base != 32 || done !== 1'b1) $display("FAIL sat_pulses: got %0d pulses done %b want 32 and 1", pulses - base, done);
    else passed++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (reg_log[base + i] !== 8'(i) || val_log[base + i] !== 8'(8'hA0 + i)) bad++;
    checks++;
    if (bad != 0) $display("FAIL sat_order: %0d of 32 pairs wrong, last got %h:%h want 1f:bf", bad, reg_log[base + 31], val_log[base + 31]);
    else passed++;
  endtask

  task automatic test_rst_mid();
    int base;
    load_basic();
    base = pulses;
    pulse_start(3);
    for (int i = 0; i < 300 && pulses - base < 2; i++) tick();
    tick(5);
    checks++;
    if (busy !== 1'b1 || i2c_busy !== 1'b1) $display("FAIL rst_mid_pre: got busy %b master %b want 1 1", busy, i2c_busy);
    else passed++;
    rst = 1;
    tick();
    checks++;
    if ({busy, done, error, i2c_start, data_0, data_1, fail_idx} !== '0) $display("FAIL rst_mid_outputs: got busy %b done %b error %b start %b d0 %h d1 %h want all 0", busy, done, error, i2c_start, data_0, data_1);
    else passed++;
    rst = 0;
    wait_master_idle();
    tick(2);
    checks++;
    if (busy !== 1'b0 || pulses - base != 2) $display("FAIL rst_mid_idle: got busy %b pulses %0d want 0 and 2", busy, pulses - base);
    else passed++;
  endtask

  task automatic test_start_held();
    int base, t;
    base = pulses;
    count = 6'd3; start = 1;
    t = 0;
    while (!done && t < 500) begin
      tick();
      t++;
    end
    start = 0;
    checks++;
    if (pulses - base != 3 || reg_log[base] !== 8'h01 || reg_log[base + 2] !== 8'h03) $display("FAIL held_pulses: got %0d pulses first %h want 3 and 01", pulses - base, reg_log[base]);
    else passed++;
    tick(3);
    checks++;
    if ({done, busy} !== 2'b10 || pulses - base != 3) $display("FAIL held_stop: got done/busy %b pulses %0d want 10 and 3", {done, busy}, pulses - base);
    else passed++;
  endtask

  task automatic test_tbl_we_run();
    int base, t;
    pulse_start(3);
    tick(10);
    write_entry(0, 8'hAA, 8'hBB);
    write_entry(1, 8'hCC, 8'hDD);
    wait_end(500, t);
    base = pulses;
    pulse_start(3);
    wait_end(500, t);
    checks++;
    if (reg_log[base] !== 8'h01 || val_log[base] !== 8'h00 || reg_log[base + 1] !== 8'h02 || val_log[base + 1] !== 8'h18) $display("FAIL tbl_we_busy: got %h:%h %h:%h want 01:00 02:18", reg_log[base], val_log[base], reg_log[base + 1], val_log[base + 1]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nack_retry();
    test_retry_exhaust();
    test_count_zero();
    test_timeout();
    test_count_sat();
    test_rst_mid();
    load_basic();
    test_start_held();
    test_tbl_we_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
